// File: rtl/ch_eqlz.sv
// ch_eqlz: per-subcarrier channel equalizer. Buffers one set of slot-0/slot-1
// channel estimates, then multiplies each data RE by conj(h) and reports |h|^2.
// Accepted REs traverse operand, product and output register stages.
module ch_eqlz #(
  parameter int WIDTH_RX  = 16,
  parameter int WIDTH_EST = 17,
  parameter int OUT_WIDTH = 17,
  parameter int N_SC      = 12
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [WIDTH_EST-1:0] h_eqlz_1_r,
  input  logic signed [WIDTH_EST-1:0] h_eqlz_1_i,
  input  logic signed [WIDTH_EST-1:0] h_eqlz_2_r,
  input  logic signed [WIDTH_EST-1:0] h_eqlz_2_i,
  input  logic                        valid_eqlz,
  input  logic signed [WIDTH_RX-1:0]  rx_r,
  input  logic signed [WIDTH_RX-1:0]  rx_i,
  input  logic                        rx_valid,
  input  logic [3:0]                  rx_sc,
  input  logic                        rx_slot,
  input  logic                        sym_done,
  output logic                        rx_ready,
  output logic signed [OUT_WIDTH-1:0] eq_r,
  output logic signed [OUT_WIDTH-1:0] eq_i,
  output logic [OUT_WIDTH-1:0]        h_pow,
  output logic                        eq_valid,
  output logic [3:0]                  eq_sc,
  output logic                        err
);

  localparam int CNT_W     = $clog2(N_SC + 1);
  localparam int PROD_W    = WIDTH_RX + WIDTH_EST + 1;
  localparam int POW_W     = 2 * WIDTH_EST + 1;
  localparam int EQ_SHIFT  = 15;
  localparam int POW_SHIFT = 16;
  localparam logic signed [PROD_W-1:0] EQ_MAX  = PROD_W'((2 ** (OUT_WIDTH - 1)) - 1);
  localparam logic signed [PROD_W-1:0] EQ_MIN  = -EQ_MAX - PROD_W'(1);
  localparam logic [POW_W-1:0]         POW_MAX = POW_W'((2 ** OUT_WIDTH) - 1);

  typedef enum logic {FILL = 1'b0, READY = 1'b1} state_t;

  // Arithmetic shift then clamp to the signed output range.
  function automatic logic signed [OUT_WIDTH-1:0] sat_eq(input logic signed [PROD_W-1:0] x);
    logic signed [PROD_W-1:0] s;
    s = x >>> EQ_SHIFT;
    if (s > EQ_MAX)      sat_eq = EQ_MAX[OUT_WIDTH-1:0];
    else if (s < EQ_MIN) sat_eq = EQ_MIN[OUT_WIDTH-1:0];
    else                 sat_eq = s[OUT_WIDTH-1:0];
  endfunction

  // Logical shift then clamp to the unsigned output range.
  function automatic logic [OUT_WIDTH-1:0] sat_pow(input logic [POW_W-1:0] x);
    logic [POW_W-1:0] s;
    s = x >> POW_SHIFT;
    if (s > POW_MAX) sat_pow = POW_MAX[OUT_WIDTH-1:0];
    else             sat_pow = s[OUT_WIDTH-1:0];
  endfunction

  state_t                state_q, state_d;
  logic                  rx_ready_q, rx_ready_d;
  logic [CNT_W-1:0]      wr_cnt_q, wr_cnt_d;
  logic                  err_q, err_d;
  logic                  wr_en;
  logic [CNT_W-1:0]      wr_idx;
  logic                  sc_ok, rx_accept;
  logic [3:0]            rd_idx;
  logic signed [WIDTH_EST-1:0] h_sel_r, h_sel_i;

  logic signed [WIDTH_EST-1:0] buf1_r_q [N_SC];
  logic signed [WIDTH_EST-1:0] buf1_i_q [N_SC];
  logic signed [WIDTH_EST-1:0] buf2_r_q [N_SC];
  logic signed [WIDTH_EST-1:0] buf2_i_q [N_SC];
  logic signed [WIDTH_EST-1:0] buf1_r_d [N_SC];
  logic signed [WIDTH_EST-1:0] buf1_i_d [N_SC];
  logic signed [WIDTH_EST-1:0] buf2_r_d [N_SC];
  logic signed [WIDTH_EST-1:0] buf2_i_d [N_SC];

  logic                        vld_p1_q, vld_p1_d;
  logic signed [WIDTH_RX-1:0]  rx_r_p1_q, rx_r_p1_d, rx_i_p1_q, rx_i_p1_d;
  logic signed [WIDTH_EST-1:0] h_r_p1_q, h_r_p1_d, h_i_p1_q, h_i_p1_d;
  logic [3:0]                  sc_p1_q, sc_p1_d;

  logic                        vld_p2_q, vld_p2_d;
  logic signed [PROD_W-1:0]    re_p2_q, re_p2_d, im_p2_q, im_p2_d;
  logic [POW_W-1:0]            pow_p2_q, pow_p2_d;
  logic [3:0]                  sc_p2_q, sc_p2_d;

  logic                        eq_valid_q, eq_valid_d;
  logic signed [OUT_WIDTH-1:0] eq_r_q, eq_r_d, eq_i_q, eq_i_d;
  logic [OUT_WIDTH-1:0]        h_pow_q, h_pow_d;
  logic [3:0]                  eq_sc_q, eq_sc_d;

  // RE acceptance: set must be complete and the subcarrier in range.
  always_comb begin
    sc_ok     = (int'(rx_sc) < N_SC);
    rx_accept = rx_valid && rx_ready_q && sc_ok;
    rd_idx    = sc_ok ? rx_sc : 4'd0;
    h_sel_r   = rx_slot ? buf2_r_q[rd_idx] : buf1_r_q[rd_idx];
    h_sel_i   = rx_slot ? buf2_i_q[rd_idx] : buf1_i_q[rd_idx];
  end

  // Fill/ready control; sym_done releases the set and may restart it at entry 0.
  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    err_d    = err_q;
    wr_en    = 1'b0;
    wr_idx   = wr_cnt_q;
    if (rx_valid && !rx_accept) err_d = 1'b1;
    if (sym_done) begin
      state_d  = FILL;
      wr_cnt_d = '0;
      if (valid_eqlz) begin
        wr_en    = 1'b1;
        wr_idx   = '0;
        wr_cnt_d = CNT_W'(1);
      end
    end else if (valid_eqlz) begin
      if (state_q == FILL) begin
        wr_en    = 1'b1;
        wr_cnt_d = wr_cnt_q + CNT_W'(1);
        if (wr_cnt_q == CNT_W'(N_SC - 1)) state_d = READY;
      end else begin
        err_d = 1'b1;
      end
    end
    rx_ready_d = (state_d == READY);
  end

  // Control state and registered rx_ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= FILL;
      rx_ready_q <= 1'b0;
      wr_cnt_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_ready_q <= rx_ready_d;
      wr_cnt_q   <= wr_cnt_d;
      err_q      <= err_d;
    end
  end

  // Estimate buffer write port.
  always_comb begin
    buf1_r_d = buf1_r_q;
    buf1_i_d = buf1_i_q;
    buf2_r_d = buf2_r_q;
    buf2_i_d = buf2_i_q;
    if (wr_en) begin
      buf1_r_d[wr_idx] = h_eqlz_1_r;
      buf1_i_d[wr_idx] = h_eqlz_1_i;
      buf2_r_d[wr_idx] = h_eqlz_2_r;
      buf2_i_d[wr_idx] = h_eqlz_2_i;
    end
  end

  // Estimate buffer storage, cleared by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < N_SC; k++) begin
        buf1_r_q[k] <= '0;
        buf1_i_q[k] <= '0;
        buf2_r_q[k] <= '0;
        buf2_i_q[k] <= '0;
      end
    end else begin
      buf1_r_q <= buf1_r_d;
      buf1_i_q <= buf1_i_d;
      buf2_r_q <= buf2_r_d;
      buf2_i_q <= buf2_i_d;
    end
  end

  // Next values for operand, product and output stages; data holds when idle.
  always_comb begin
    // stage p1: operands captured with their estimate
    vld_p1_d  = rx_accept;
    rx_r_p1_d = rx_accept ? rx_r    : rx_r_p1_q;
    rx_i_p1_d = rx_accept ? rx_i    : rx_i_p1_q;
    h_r_p1_d  = rx_accept ? h_sel_r : h_r_p1_q;
    h_i_p1_d  = rx_accept ? h_sel_i : h_i_p1_q;
    sc_p1_d   = rx_accept ? rx_sc   : sc_p1_q;
    // stage p2: full-precision rx * conj(h) and |h|^2
    vld_p2_d  = vld_p1_q;
    re_p2_d   = re_p2_q;
    im_p2_d   = im_p2_q;
    pow_p2_d  = pow_p2_q;
    sc_p2_d   = sc_p2_q;
    if (vld_p1_q) begin
      re_p2_d  = PROD_W'(rx_r_p1_q) * PROD_W'(h_r_p1_q) + PROD_W'(rx_i_p1_q) * PROD_W'(h_i_p1_q);
      im_p2_d  = PROD_W'(rx_i_p1_q) * PROD_W'(h_r_p1_q) - PROD_W'(rx_r_p1_q) * PROD_W'(h_i_p1_q);
      pow_p2_d = $unsigned(POW_W'(h_r_p1_q) * POW_W'(h_r_p1_q) + POW_W'(h_i_p1_q) * POW_W'(h_i_p1_q));
      sc_p2_d  = sc_p1_q;
    end
    // stage out: scale and saturate
    eq_valid_d = vld_p2_q;
    eq_r_d     = vld_p2_q ? sat_eq(re_p2_q)   : eq_r_q;
    eq_i_d     = vld_p2_q ? sat_eq(im_p2_q)   : eq_i_q;
    h_pow_d    = vld_p2_q ? sat_pow(pow_p2_q) : h_pow_q;
    eq_sc_d    = vld_p2_q ? sc_p2_q           : eq_sc_q;
  end

  // Pipeline registers; reset discards in-flight REs and zeroes outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1_q   <= 1'b0;
      rx_r_p1_q  <= '0;
      rx_i_p1_q  <= '0;
      h_r_p1_q   <= '0;
      h_i_p1_q   <= '0;
      sc_p1_q    <= '0;
      vld_p2_q   <= 1'b0;
      re_p2_q    <= '0;
      im_p2_q    <= '0;
      pow_p2_q   <= '0;
      sc_p2_q    <= '0;
      eq_valid_q <= 1'b0;
      eq_r_q     <= '0;
      eq_i_q     <= '0;
      h_pow_q    <= '0;
      eq_sc_q    <= '0;
    end else begin
      vld_p1_q   <= vld_p1_d;
      rx_r_p1_q  <= rx_r_p1_d;
      rx_i_p1_q  <= rx_i_p1_d;
      h_r_p1_q   <= h_r_p1_d;
      h_i_p1_q   <= h_i_p1_d;
      sc_p1_q    <= sc_p1_d;
      vld_p2_q   <= vld_p2_d;
      re_p2_q    <= re_p2_d;
      im_p2_q    <= im_p2_d;
      pow_p2_q   <= pow_p2_d;
      sc_p2_q    <= sc_p2_d;
      eq_valid_q <= eq_valid_d;
      eq_r_q     <= eq_r_d;
      eq_i_q     <= eq_i_d;
      h_pow_q    <= h_pow_d;
      eq_sc_q    <= eq_sc_d;
    end
  end

  assign rx_ready = rx_ready_q;
  assign err      = err_q;
  assign eq_valid = eq_valid_q;
  assign eq_r     = eq_r_q;
  assign eq_i     = eq_i_q;
  assign h_pow    = h_pow_q;
  assign eq_sc    = eq_sc_q;

endmodule

// File: tb/tb_ch_eqlz.sv
// tb_ch_eqlz: scoreboard bench for ch_eqlz with a behavioural estimate-set model.
module tb_ch_eqlz;
  localparam int NSC = 12;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic signed [16:0] h_eqlz_1_r, h_eqlz_1_i, h_eqlz_2_r, h_eqlz_2_i;
  logic valid_eqlz;
  logic signed [15:0] rx_r, rx_i;
  logic rx_valid;
  logic [3:0] rx_sc;
  logic rx_slot, sym_done;
  logic rx_ready;
  logic signed [16:0] eq_r, eq_i;
  logic [16:0] h_pow;
  logic eq_valid;
  logic [3:0] eq_sc;
  logic err;

  ch_eqlz dut (
    .clk(clk), .rst(rst),
    .h_eqlz_1_r(h_eqlz_1_r), .h_eqlz_1_i(h_eqlz_1_i),
    .h_eqlz_2_r(h_eqlz_2_r), .h_eqlz_2_i(h_eqlz_2_i),
    .valid_eqlz(valid_eqlz),
    .rx_r(rx_r), .rx_i(rx_i), .rx_valid(rx_valid), .rx_sc(rx_sc),
    .rx_slot(rx_slot), .sym_done(sym_done),
    .rx_ready(rx_ready), .eq_r(eq_r), .eq_i(eq_i), .h_pow(h_pow),
    .eq_valid(eq_valid), .eq_sc(eq_sc), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint r;
    longint i;
    longint p;
    longint sc;
    longint due;
  } exp_t;

  exp_t   q[$];
  exp_t   last;
  longint cyc = 0;
  int     checks = 0;
  int     errors = 0;

  // Reference state: estimate set contents, fill count, ready flag, sticky error.
  longint m_b1r[NSC], m_b1i[NSC], m_b2r[NSC], m_b2i[NSC];
  int     m_cnt;
  bit     m_ready, m_err;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // rx * conj(h): real/imag scaled by 2^-15 (floor), |h|^2 scaled by 2^-16, then clamped.
  function automatic exp_t calc(longint rr, longint ri, longint hr, longint hi, longint sc);
    exp_t e;
    longint a, b, p;
    a = (rr * hr + ri * hi) >>> 15;
    b = (ri * hr - rr * hi) >>> 15;
    p = (hr * hr + hi * hi) >> 16;
    if (a > 65535) a = 65535;
    if (a < -65536) a = -65536;
    if (b > 65535) b = 65535;
    if (b < -65536) b = -65536;
    if (p > 131071) p = 131071;
    e.r = a; e.i = b; e.p = p; e.sc = sc; e.due = 0;
    return e;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < NSC; k++) begin
      m_b1r[k] = 0; m_b1i[k] = 0; m_b2r[k] = 0; m_b2i[k] = 0;
    end
    m_cnt = 0; m_ready = 0; m_err = 0;
    q.delete();
    last = '{0, 0, 0, 0, 0};
  endtask

  task automatic mwrite(input int idx);
    m_b1r[idx] = h_eqlz_1_r; m_b1i[idx] = h_eqlz_1_i;
    m_b2r[idx] = h_eqlz_2_r; m_b2i[idx] = h_eqlz_2_i;
  endtask

  // Effect of the inputs currently driven, as seen at the coming clock edge.
  task automatic model_step();
    exp_t e;
    bit   acc;
    if (!rst) begin
      model_clear();
      return;
    end
    acc = rx_valid && m_ready && (rx_sc < NSC);
    if (rx_valid && !acc) m_err = 1;
    if (acc) begin
      if (rx_slot) e = calc(rx_r, rx_i, m_b2r[rx_sc], m_b2i[rx_sc], rx_sc);
      else         e = calc(rx_r, rx_i, m_b1r[rx_sc], m_b1i[rx_sc], rx_sc);
      e.due = cyc + 3;
      q.push_back(e);
    end
    if (sym_done) begin
      m_cnt = 0; m_ready = 0;
      if (valid_eqlz) begin mwrite(0); m_cnt = 1; end
    end else if (valid_eqlz) begin
      if (!m_ready) begin
        mwrite(m_cnt);
        m_cnt++;
        if (m_cnt == NSC) m_ready = 1;
      end else begin
        m_err = 1;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("rx_ready", rx_ready, m_ready);
    chk("err", err, m_err);
  endtask

  task automatic idle();
    valid_eqlz = 0; rx_valid = 0; sym_done = 0; rx_slot = 0; rx_sc = 0;
    rx_r = 0; rx_i = 0;
    h_eqlz_1_r = 0; h_eqlz_1_i = 0; h_eqlz_2_r = 0; h_eqlz_2_i = 0;
  endtask

  function automatic int rnd_est();
    case ($urandom_range(0, 7))
      0: return -65536;
      1: return 65535;
      default: return int'($urandom_range(0, 131071)) - 65536;
    endcase
  endfunction

  function automatic int rnd_rx();
    case ($urandom_range(0, 7))
      0: return -32768;
      1: return 32767;
      default: return int'($urandom_range(0, 65535)) - 32768;
    endcase
  endfunction

  task automatic wr(input int a, input int b, input int c, input int d, input bit sd);
    h_eqlz_1_r = 17'(a); h_eqlz_1_i = 17'(b);
    h_eqlz_2_r = 17'(c); h_eqlz_2_i = 17'(d);
    valid_eqlz = 1; sym_done = sd;
    tick();
    idle();
  endtask

  task automatic send_re(input int a, input int b, input int sc, input bit slot);
    rx_r = 16'(a); rx_i = 16'(b); rx_sc = 4'(sc); rx_slot = slot; rx_valid = 1;
    tick();
    idle();
  endtask

  task automatic fill_rand(input int n);
    for (int k = 0; k < n; k++) wr(rnd_est(), rnd_est(), rnd_est(), rnd_est(), 0);
  endtask

  task automatic drain(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset(input int n);
    rst = 0;
    model_clear();
    #1;
    chk("rst_eq_valid", eq_valid, 0);
    chk("rst_eq_r", eq_r, 0);
    chk("rst_eq_i", eq_i, 0);
    chk("rst_h_pow", h_pow, 0);
    chk("rst_eq_sc", eq_sc, 0);
    chk("rst_rx_ready", rx_ready, 0);
    chk("rst_err", err, 0);
    repeat (n) tick();
    rst = 1;
  endtask

  // Scoreboard monitor: pops one expectation per eq_valid pulse, otherwise checks hold.
  always @(negedge clk) begin
    exp_t e;
    if (eq_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_eq_valid: got pulse with eq_sc=%0d, expected none (cycle %0d)", eq_sc, cyc);
      end else begin
        e = q.pop_front();
        chk("eq_r", eq_r, e.r);
        chk("eq_i", eq_i, e.i);
        chk("h_pow", h_pow, e.p);
        chk("eq_sc", eq_sc, e.sc);
        chk("latency_cycle", cyc, e.due);
        last = e;
      end
    end else begin
      chk("hold_eq_r", eq_r, last.r);
      chk("hold_eq_i", eq_i, last.i);
      chk("hold_h_pow", h_pow, last.p);
      chk("hold_eq_sc", eq_sc, last.sc);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    model_clear();
    rst = 0;
    repeat (3) tick();
    chk("rst_eq_valid", eq_valid, 0);
    chk("rst_eq_r", eq_r, 0);
    chk("rst_h_pow", h_pow, 0);
    chk("rst_rx_ready", rx_ready, 0);
    chk("rst_err", err, 0);
    rst = 1;

    // Fill: h1 = 32768+j0 everywhere, h2[3] = 0+j32768.
    for (int k = 0; k < NSC; k++) begin
      if (k == 3) wr(32768, 0, 0, 32768, 0);
      else        wr(32768, 0, rnd_est(), rnd_est(), 0);
      if (k == NSC - 2) chk("ready_before_last", rx_ready, 0);
    end
    chk("ready_after_fill", rx_ready, 1);
    chk("err_after_fill", err, 0);

    // Pass-through on slot 0.
    send_re(1234, 3456, 5, 0);
    drain(2);
    chk("pt_valid", eq_valid, 1);
    chk("pt_eq_r", eq_r, 1234);
    chk("pt_eq_i", eq_i, 3456);
    chk("pt_h_pow", h_pow, 16384);
    chk("pt_eq_sc", eq_sc, 5);

    // Conjugate with slot-1 select.
    send_re(1000, 0, 3, 1);
    drain(2);
    chk("cj_valid", eq_valid, 1);
    chk("cj_eq_r", eq_r, 0);
    chk("cj_eq_i", eq_i, -1000);
    chk("cj_h_pow", h_pow, 16384);

    // 12 back-to-back REs.
    for (int k = 0; k < NSC; k++) send_re(rnd_rx(), rnd_rx(), k, 1'($urandom_range(0, 1)));
    drain(4);

    // 13th estimate while ready: ignored, sets err.
    wr(7, 7, 7, 7, 0);
    chk("err_13th", err, 1);
    send_re(rnd_rx(), rnd_rx(), 0, 0);
    send_re(rnd_rx(), rnd_rx(), 0, 1);
    drain(4);

    // Out-of-range subcarrier.
    do_reset(2);
    fill_rand(NSC);
    send_re(500, 500, 13, 0);
    chk("err_sc13", err, 1);
    drain(4);

    // RE before the set is complete.
    do_reset(2);
    fill_rand(5);
    send_re(500, 500, 2, 0);
    chk("err_early_rx", err, 1);
    fill_rand(NSC - 5);
    drain(3);

    // sym_done with valid_eqlz restarts at entry 0; 11 more writes complete the set.
    wr(65535, 65535, rnd_est(), rnd_est(), 1);
    chk("release_ready", rx_ready, 0);
    fill_rand(NSC - 2);
    chk("refill_ready_10", rx_ready, 0);
    fill_rand(1);
    chk("refill_ready_11", rx_ready, 1);

    // Saturation.
    send_re(32767, 32767, 0, 0);
    drain(2);
    chk("sat_valid", eq_valid, 1);
    chk("sat_eq_r", eq_r, 65535);
    chk("sat_eq_i", eq_i, 0);
    chk("sat_h_pow", h_pow, 131068);

    // sym_done while REs are in flight.
    send_re(rnd_rx(), rnd_rx(), 4, 0);
    sym_done = 1;
    send_re(rnd_rx(), rnd_rx(), 6, 1);
    drain(4);
    fill_rand(NSC);

    // Reset with two REs in flight.
    send_re(rnd_rx(), rnd_rx(), 1, 0);
    send_re(rnd_rx(), rnd_rx(), 2, 1);
    do_reset(2);
    drain(6);

    // Randomized traffic.
    for (int k = 0; k < 1500; k++) begin
      valid_eqlz = m_ready ? ($urandom_range(0, 31) == 0) : ($urandom_range(0, 3) != 0);
      h_eqlz_1_r = 17'(rnd_est()); h_eqlz_1_i = 17'(rnd_est());
      h_eqlz_2_r = 17'(rnd_est()); h_eqlz_2_i = 17'(rnd_est());
      sym_done   = ($urandom_range(0, 59) == 0);
      rx_valid   = ($urandom_range(0, 3) != 0);
      rx_sc      = ($urandom_range(0, 15) == 0) ? 4'(12 + $urandom_range(0, 3)) : 4'($urandom_range(0, 11));
      rx_slot    = 1'($urandom_range(0, 1));
      rx_r       = 16'(rnd_rx());
      rx_i       = 16'(rnd_rx());
      tick();
    end
    idle();
    drain(8);
    chk("queue_empty", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ch_eqlz.md
CH_EQLZ -- requirements
Module: ch_eqlz

Interface
REQ-001 SHALL have parameters: WIDTH_RX 16 (received sample width); WIDTH_EST 17 (channel estimate width); OUT_WIDTH 17 (equalized output width); N_SC 12 (subcarriers per estimate set).
REQ-002 SHALL have ports:
- clk  in  1  single system clock.
- rst  in  1  asynchronous, active-low reset.
- h_eqlz_1_r, h_eqlz_1_i  in  WIDTH_EST  signed slot-0 channel estimate.
- h_eqlz_2_r, h_eqlz_2_i  in  WIDTH_EST  signed slot-1 channel estimate.
- valid_eqlz  in  1  estimate pair valid for the next subcarrier.
- rx_r, rx_i  in  WIDTH_RX  signed demapped data resource element (RE).
- rx_valid  in  1  data RE valid.
- rx_sc  in  4  subcarrier index of the RE.
- rx_slot  in  1  slot of the RE (0 selects h_eqlz_1, 1 selects h_eqlz_2).
- sym_done  in  1  one-cycle pulse that releases the estimate set.
- rx_ready  out  1  estimate set complete; data accepted.
- eq_r, eq_i  out  OUT_WIDTH  signed rx multiplied by conj(h).
- h_pow  out  OUT_WIDTH  unsigned |h|^2.
- eq_valid  out  1  eq_r, eq_i and h_pow valid.
- eq_sc  out  4  subcarrier index of the output.
- err  out  1  sticky error flag.

Function
REQ-003 SHALL hold two N_SC-entry register buffers, buf1 and buf2, each entry a complex estimate of WIDTH_EST bits per part.
REQ-004 SHALL keep a write counter wr_cnt (0..N_SC) and a state machine with two states.
- FILL: rx_ready=0.
- READY: rx_ready=1.
REQ-005 In FILL, each cycle with valid_eqlz=1 SHALL write h_eqlz_1 to buf1[wr_cnt] and h_eqlz_2 to buf2[wr_cnt], then increment wr_cnt.
REQ-006 The write of entry N_SC-1 SHALL move the block to READY on the next edge; rx_ready SHALL rise in the cycle after that write.
REQ-007 valid_eqlz in READY SHALL be ignored (buffers unchanged) and SHALL set err.
REQ-008 sym_done in any state SHALL clear wr_cnt and return the block to FILL; buffer contents SHALL NOT be cleared.
REQ-009 sym_done and valid_eqlz in the same cycle SHALL release the set and write the estimate to entry 0, leaving wr_cnt=1 and the state FILL.
REQ-010 rx_valid while rx_ready=0 SHALL be dropped and SHALL set err.
REQ-011 rx_valid with rx_sc>N_SC-1 SHALL be dropped, SHALL set err and SHALL NOT produce eq_valid.
REQ-012 Pipeline stage 1: an accepted RE SHALL register rx, rx_sc, and the buffer entry selected by rx_slot and rx_sc.
REQ-013 Pipeline stage 2 SHALL compute:
- re = rx_r*h_r + rx_i*h_i, at full precision (34 bits).
- im = rx_i*h_r - rx_r*h_i, at full precision (34 bits).
- p = h_r^2 + h_i^2.
REQ-014 eq_r and eq_i SHALL equal re and im arithmetically shifted right by 15, saturated to a signed OUT_WIDTH range of [-65536, 65535].
REQ-015 h_pow SHALL equal p shifted right by 16, saturated to 131071.
REQ-016 Latency SHALL be exactly 2 cycles: RE accepted at edge n gives eq_valid=1 during the cycle after edge n+2.
REQ-017 Throughput SHALL be one RE per cycle, with no stalls.
REQ-018 eq_valid SHALL be a per-RE pulse; eq_r, eq_i, h_pow and eq_sc SHALL hold their last values when eq_valid=0.
REQ-019 A sym_done arriving while REs are in flight SHALL NOT corrupt them; in-flight REs complete with the estimates already registered.

Reset
REQ-020 While rst=0, the block SHALL asynchronously clear:
- all outputs to 0;
- wr_cnt to 0;
- state to FILL;
- pipeline valid bits to 0;
- err to 0.
REQ-021 Buffer contents SHALL also be cleared by reset.
REQ-022 Reset mid-operation SHALL discard in-flight REs with no eq_valid pulse after release.
REQ-023 Only reset SHALL clear err.

Verification
REQ-024 Fill: 12 valid_eqlz cycles with h1=32768+j0 -> rx_ready=1 in the cycle after the 12th write; err=0.
REQ-025 Pass-through: rx=1234+j3456, slot 0, sc 5 -> 2 cycles later eq=1234+j3456, h_pow=16384, eq_sc=5.
REQ-026 Conjugate and slot select: buf2[3]=0+j32768, rx=1000+j0, slot 1, sc 3 -> eq=0-j1000, h_pow=16384.
REQ-027 Saturation: h=65535+j65535, rx=32767+j32767 -> eq_r=65535, eq_i=0, h_pow=131068.
REQ-028 Errors: rx_valid before the fill completes, rx_sc=13, and a 13th valid_eqlz each -> no eq_valid pulse and err=1; 12 back-to-back REs -> 12 consecutive eq_valid pulses.
REQ-029 Release and reset:
- sym_done together with valid_eqlz -> rx_ready=0 and wr_cnt=1.
- rst=0 while 2 REs are in flight -> all outputs 0 and no eq_valid pulse after release.
